// File: rtl/axis_frame_capture.sv
// Frame-aligned AXI4-Stream capture buffer: syncs to tlast, optionally skips whole
// frames, then stores frames in RAM in single-shot or ring (pre-stop history) mode.
module axis_frame_capture #(
  parameter int WIDTH    = 32,
  parameter int FFT_LEN  = 64,
  parameter int FRAMES   = 32,
  parameter int SKIP_WID = 8,
  parameter int CNT_WID  = 16,
  localparam int DEPTH   = FRAMES * FFT_LEN,
  localparam int AW      = $clog2(DEPTH),
  localparam int IW      = $clog2(FFT_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  input  logic                arm,
  input  logic                stop,
  input  logic                mode,
  input  logic [SKIP_WID-1:0] skip_frames,
  input  logic                rd_en,
  input  logic [AW-1:0]       rd_addr,
  output logic [WIDTH-1:0]    rd_data,
  output logic                busy,
  output logic                full,
  output logic                wrapped,
  output logic [AW-1:0]       wr_ptr,
  output logic [CNT_WID-1:0]  frame_count,
  output logic [CNT_WID-1:0]  tlast_err_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_SKIP,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [IW-1:0]      IDX_LAST = IW'(FFT_LEN - 1);
  localparam logic [AW-1:0]      PTR_LAST = AW'(DEPTH - 1);
  localparam logic [CNT_WID-1:0] CNT_MAX  = '1;

  state_t              state;
  logic                mode_q;
  logic [SKIP_WID-1:0] skip_q;
  logic [IW-1:0]       idx;
  logic                stop_pend;
  logic                beat;
  logic                idx_last;
  logic                wr_en;
  logic [WIDTH-1:0]    ram [DEPTH];

  function automatic logic [CNT_WID-1:0] sat_inc(input logic [CNT_WID-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_WID'(1);
  endfunction

  assign beat     = s_axis_tvalid & s_axis_tready;
  assign idx_last = (idx == IDX_LAST);
  assign wr_en    = beat && (state == S_CAPTURE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      s_axis_tready   <= 1'b0;
      busy            <= 1'b0;
      full            <= 1'b0;
      wrapped         <= 1'b0;
      wr_ptr          <= '0;
      frame_count     <= '0;
      tlast_err_count <= '0;
      mode_q          <= 1'b0;
      skip_q          <= '0;
      idx             <= '0;
      stop_pend       <= 1'b0;
    end else begin
      s_axis_tready <= 1'b1;
      case (state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            state           <= S_WAIT_SOF;
            busy            <= 1'b1;
            full            <= 1'b0;
            wrapped         <= 1'b0;
            wr_ptr          <= '0;
            frame_count     <= '0;
            tlast_err_count <= '0;
            idx             <= '0;
            stop_pend       <= 1'b0;
            mode_q          <= mode;
            skip_q          <= skip_frames;
          end
        end
        S_WAIT_SOF: begin
          if (stop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (beat && s_axis_tlast) begin
            state <= (skip_q != '0) ? S_SKIP : S_CAPTURE;
          end
        end
        S_SKIP: begin
          if (stop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (beat && s_axis_tlast) begin
            skip_q <= skip_q - SKIP_WID'(1);
            if (skip_q == SKIP_WID'(1)) state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          // A ring-mode stop only takes effect at the end of the current frame.
          if (stop && mode_q) stop_pend <= 1'b1;
          if (beat) begin
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);
            idx    <= (s_axis_tlast || idx_last) ? '0 : idx + IW'(1);
            if (idx_last) frame_count <= sat_inc(frame_count);
            if (s_axis_tlast != idx_last) tlast_err_count <= sat_inc(tlast_err_count);
            if (mode_q && wr_ptr == PTR_LAST) wrapped <= 1'b1;
            if ((!mode_q && wr_ptr == PTR_LAST) ||
                (mode_q && idx_last && (stop_pend || stop))) begin
              state <= S_DONE;
              busy  <= 1'b0;
              full  <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          full  <= 1'b0;
        end
      endcase
    end
  end

  // RAM contents survive reset; read port is read-first against the write port.
  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_ptr] <= s_axis_tdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else if (rd_en) rd_data <= ram[rd_addr];
  end

endmodule

// File: tb/tb_axis_frame_capture.sv
// Directed bench for axis_frame_capture: a frame-level reference model checked every
// cycle, plus literal expectations for each capture scenario.
module tb_axis_frame_capture;
  localparam int WIDTH = 32, FFT_LEN = 8, FRAMES = 4, SKIP_WID = 8, CNT_WID = 16;
  localparam int DEPTH = FRAMES * FFT_LEN;
  localparam int AW = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [WIDTH-1:0]    s_axis_tdata;
  logic                s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic                arm, stop, mode, rd_en;
  logic [SKIP_WID-1:0] skip_frames;
  logic [AW-1:0]       rd_addr, wr_ptr;
  logic [WIDTH-1:0]    rd_data;
  logic                busy, full, wrapped;
  logic [CNT_WID-1:0]  frame_count, tlast_err_count;

  always #5 clk = ~clk;

  axis_frame_capture #(
    .WIDTH(WIDTH), .FFT_LEN(FFT_LEN), .FRAMES(FRAMES), .SKIP_WID(SKIP_WID), .CNT_WID(CNT_WID)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .arm(arm), .stop(stop), .mode(mode), .skip_frames(skip_frames),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .full(full), .wrapped(wrapped), .wr_ptr(wr_ptr),
    .frame_count(frame_count), .tlast_err_count(tlast_err_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phases of a capture, total words written since arm, position in frame.
  typedef enum int {P_IDLE, P_SYNC, P_SKIP, P_CAP, P_DONE} phase_t;
  phase_t      ph = P_IDLE;
  int          nwr = 0, fc = 0, ec = 0, pos = 0, skip_left = 0;
  bit          ring = 0, stop_req = 0, m_tready = 0, chk_en = 0;
  logic [31:0] mem [DEPTH];
  logic [31:0] m_rd = '0;

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_step();
    bit bt, tl, eof;
    if (rst) begin
      ph = P_IDLE; nwr = 0; fc = 0; ec = 0; pos = 0; skip_left = 0;
      ring = 0; stop_req = 0; m_tready = 0; m_rd = '0; chk_en = 1;
    end else begin
      bt = s_axis_tvalid && m_tready;
      tl = s_axis_tlast;
      if (rd_en) m_rd = mem[rd_addr];
      case (ph)
        P_IDLE, P_DONE:
          if (arm) begin
            ph = P_SYNC; nwr = 0; fc = 0; ec = 0; pos = 0;
            ring = mode; skip_left = int'(skip_frames); stop_req = 0;
          end
        P_SYNC:
          if (stop) ph = P_IDLE;
          else if (bt && tl) ph = (skip_left > 0) ? P_SKIP : P_CAP;
        P_SKIP:
          if (stop) ph = P_IDLE;
          else if (bt && tl) begin
            skip_left--;
            if (skip_left == 0) ph = P_CAP;
          end
        P_CAP: begin
          if (stop && ring) stop_req = 1;
          if (bt) begin
            mem[nwr % DEPTH] = s_axis_tdata;
            nwr++;
            eof = (pos == FFT_LEN - 1);
            if (eof) fc = sat(fc);
            if (tl != eof) ec = sat(ec);
            pos = (tl || eof) ? 0 : pos + 1;
            if (!ring && nwr == DEPTH) ph = P_DONE;
            else if (ring && eof && stop_req) ph = P_DONE;
          end
        end
        default: ph = P_IDLE;
      endcase
      m_tready = 1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("tready", 64'(s_axis_tready), 64'(m_tready));
      chk("busy", 64'(busy), 64'(ph == P_SYNC || ph == P_SKIP || ph == P_CAP));
      chk("full", 64'(full), 64'(ph == P_DONE));
      chk("wrapped", 64'(wrapped), 64'(ring && nwr >= DEPTH));
      chk("wr_ptr", 64'(wr_ptr), 64'(nwr % DEPTH));
      chk("frame_count", 64'(frame_count), 64'(fc));
      chk("tlast_err_count", 64'(tlast_err_count), 64'(ec));
      chk("rd_data", 64'(rd_data), 64'(m_rd));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_arm(input bit m, input logic [7:0] sk);
    arm = 1'b1; mode = m; skip_frames = sk;
    tick();
    arm = 1'b0;
  endtask

  // n beats of running-count data; tlast at frame phase FFT_LEN-1 unless overridden.
  task automatic stream(input int n, input int c0, input int ph0, input int early_at,
                        input int miss_at, input int stop_at, input bit rnd);
    int fph;
    bit tl;
    fph = ph0;
    for (int k = 0; k < n; k++) begin
      int c;
      c = c0 + k;
      if (rnd) begin
        for (int g = 0; g < 4 && $urandom_range(1, 0) == 1; g++) begin
          s_axis_tvalid = 1'b0;
          s_axis_tdata  = 32'hDEAD0000 | 32'(k);
          s_axis_tlast  = 1'($urandom_range(1, 0));
          stop = 1'b0;
          tick();
        end
      end
      tl = (fph == FFT_LEN - 1);
      if (c == early_at) tl = 1'b1;
      if (c == miss_at) tl = 1'b0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'(c);
      s_axis_tlast  = tl;
      stop = (c == stop_at);
      tick();
      fph = (tl || fph == FFT_LEN - 1) ? 0 : fph + 1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    stop = 1'b0;
  endtask

  task automatic read_chk(input int a, input int exp);
    rd_en = 1'b1;
    rd_addr = a[4:0];
    tick();
    rd_en = 1'b0;
    chk($sformatf("ram[%0d]", a), 64'(rd_data), 64'(exp));
  endtask

  initial begin
    rst = 1'b1; s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    arm = 1'b0; stop = 1'b0; mode = 1'b0; skip_frames = '0; rd_en = 1'b0; rd_addr = '0;
    tick();
    chk("rst_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_frame_count", 64'(frame_count), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("tready_after_rst", 64'(s_axis_tready), 64'd1);

    // Single-shot, stream enters mid-frame at idx 5
    pulse_arm(1'b0, 8'd0);
    stream(40, 0, 5, -1, -1, -1, 1'b0);
    chk("s1_full", 64'(full), 64'd1);
    chk("s1_frame_count", 64'(frame_count), 64'd4);
    chk("s1_err", 64'(tlast_err_count), 64'd0);
    for (int a = 0; a < DEPTH; a++) read_chk(a, 3 + a);

    // Skip two frames after sync
    pulse_arm(1'b0, 8'd2);
    stream(60, 0, 5, -1, -1, -1, 1'b0);
    chk("s2_full", 64'(full), 64'd1);
    read_chk(0, 19);
    read_chk(31, 50);

    // stop in WAIT_SOF aborts; stop in IDLE ignored; arm+stop in IDLE arms
    pulse_arm(1'b1, 8'd0);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_sync_busy", 64'(busy), 64'd0);
    stop = 1'b1; tick(); stop = 1'b0;
    arm = 1'b1; stop = 1'b1; mode = 1'b1; skip_frames = 8'd0; tick();
    arm = 1'b0; stop = 1'b0;
    chk("arm_stop_idle_busy", 64'(busy), 64'd1);

    // Ring mode: already in WAIT_SOF; 10 frames, stop in last frame at idx 3
    stream(90, 0, 5, -1, -1, 78, 1'b0);
    chk("s3_full", 64'(full), 64'd1);
    chk("s3_wrapped", 64'(wrapped), 64'd1);
    chk("s3_wr_ptr", 64'(wr_ptr), 64'd16);
    chk("s3_frame_count", 64'(frame_count), 64'd10);
    read_chk(16, 51);
    read_chk(31, 66);
    read_chk(0, 67);
    read_chk(15, 82);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_done_full", 64'(full), 64'd1);

    // Early tlast at idx 4, missing tlast at idx 7; arm+stop together from DONE
    arm = 1'b1; stop = 1'b1; mode = 1'b0; skip_frames = 8'd0; tick();
    arm = 1'b0; stop = 1'b0;
    stream(40, 0, 7, 5, 13, -1, 1'b0);
    chk("s4_full", 64'(full), 64'd1);
    chk("s4_err", 64'(tlast_err_count), 64'd2);
    chk("s4_frame_count", 64'(frame_count), 64'd3);
    read_chk(4, 5);
    read_chk(5, 6);
    read_chk(12, 13);
    read_chk(31, 32);

    // Random tvalid gaps give the scenario-1 image
    pulse_arm(1'b0, 8'd0);
    stream(40, 0, 5, -1, -1, -1, 1'b1);
    chk("s5_full", 64'(full), 64'd1);
    chk("s5_frame_count", 64'(frame_count), 64'd4);
    for (int a = 0; a < DEPTH; a++) read_chk(a, 3 + a);

    // Reset mid-capture, then re-arm; a second arm while busy is ignored
    pulse_arm(1'b0, 8'd0);
    stream(12, 200, 5, -1, -1, -1, 1'b0);
    chk("s6_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1; tick();
    chk("s6_busy", 64'(busy), 64'd0);
    chk("s6_wr_ptr", 64'(wr_ptr), 64'd0);
    chk("s6_frame_count", 64'(frame_count), 64'd0);
    chk("s6_err", 64'(tlast_err_count), 64'd0);
    rst = 1'b0; tick();
    pulse_arm(1'b0, 8'd0);
    pulse_arm(1'b1, 8'd3);
    mode = 1'b0; skip_frames = 8'd0;
    stream(40, 100, 5, -1, -1, -1, 1'b0);
    chk("s6_full", 64'(full), 64'd1);
    chk("s6_wrapped", 64'(wrapped), 64'd0);
    read_chk(0, 103);
    read_chk(31, 134);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
